z_word_packer: RTL and testbench
================================

# z_word_packer

Downstream consumer of the serial Mealy-FSM output `Z`. Samples `Z` on qualified clock edges and packs the bits MSB-first into `WIDTH`-bit words. Each completed word is presented, with its population count, on a valid/ready output port. Words that complete while the output register is still occupied are dropped, and a sticky drop flag is raised.

## Interface
Parameters:
- `WIDTH`, 8: bits per packed word; legal range 2–32.
- `CW`, `$clog2(WIDTH+1)`: width of the ones count; derived, not overridden.

Ports:
- `CLK`, input, 1: single clock; all logic on posedge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Z`, input, 1: serial bit from the upstream FSM.
- `Z_en`, input, 1: sample qualifier; `Z` is captured only on edges where `Z_en` = 1.
- `Word_out`, output, `WIDTH`: packed word; the first-sampled bit is in `[WIDTH-1]`.
- `Ones_out`, output, `CW`: number of 1s in `Word_out`.
- `Word_valid`, output, 1: `Word_out`/`Ones_out` hold an unconsumed word.
- `Word_ready`, input, 1: consumer accepts the word when `Word_valid` && `Word_ready` at an edge.
- `Drop`, output, 1: sticky; a completed word was lost because the output register was full.
- `Fill_cnt`, output, `CW`: number of bits currently in the partial word (0..`WIDTH`-1).

## Operation
- **Reset** (sampled at posedge `CLK` with `Reset` = 1) clears all outputs:
  - shift register = 0, `Fill_cnt` = 0;
  - `Word_out` = 0, `Ones_out` = 0, `Word_valid` = 0, `Drop` = 0;
  - output FSM goes to EMPTY.
  - Reset overrides every other input on that edge.
- **Fill path** (edge with `Z_en` = 1):
  - shift register ← {shift[`WIDTH`-2:0], `Z`};
  - `Fill_cnt` increments.
  - When `Fill_cnt` = `WIDTH`-1 at that edge, the word is complete:
    - the full word {shift[`WIDTH`-2:0], `Z`} is offered to the output stage;
    - `Fill_cnt` wraps to 0 and the shift register is cleared.
- **`Z_en` = 0:** the fill path holds; the partial word is preserved indefinitely.
- **Output FSM states:** EMPTY (`Word_valid` = 0) and FULL (`Word_valid` = 1).
  - EMPTY, word completes → load `Word_out`/`Ones_out`, go to FULL.
  - FULL, handshake (`Word_ready` = 1), no completion → EMPTY.
  - FULL, handshake and completion on the same edge → load the new word, stay FULL; no drop.
  - FULL, no handshake, completion → discard the new word, set `Drop` = 1, stay FULL; the held word is unchanged.
  - FULL, neither event → hold.
- **Hold rule:** `Word_out`/`Ones_out` must not change while FULL without a handshake.
- **`Drop`** clears only on `Reset`.
- **`Ones_out`** is the popcount of the word being loaded, computed combinationally and registered together with `Word_out`.
- **`Word_ready` while EMPTY** is ignored.

## Timing
- **Load latency:** the completing bit is sampled at edge k; `Word_valid` and the new `Word_out` are visible after edge k, i.e. during cycle k+1.
- **Throughput:** a back-to-back `Z_en` stream with `Word_ready` tied high sustains one word per `WIDTH` cycles with no drops.
- **Handshake:** `Word_valid` deasserts the cycle after the accepting edge, unless a new word loads on that same edge.
- **`Fill_cnt`:** registered; updates one cycle after the sampling edge.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.
- **Reset mid-word:** the partial word is discarded; the next sampled bit becomes the MSB of a new word.

## Structure
- Shared package `z_pack_pkg`:
  - `WIDTH_DEFAULT` = 8;
  - output state typedef `out_state_t` {EMPTY, FULL}.
- Sub-module `popcount #(WIDTH)`: purely combinational; input `WIDTH` bits, output `CW` bits. It is instantiated once on the completed-word bus.
- The top-level module holds the shift register, fill counter, output register and the 2-state FSM.

## Test plan
- **Reset/idle:** assert `Reset` 2 cycles, release, hold `Z_en` = 0 for 10 cycles → all outputs 0, `Fill_cnt` = 0.
- **Basic pack:** `WIDTH` = 8, `Word_ready` = 1, feed `Z` = 1,0,1,1,0,0,1,0 on consecutive `Z_en` edges → one cycle after the 8th bit: `Word_out` = 8'hB2, `Ones_out` = 4, `Word_valid` = 1 for one cycle, `Drop` = 0.
- **Gapped enable:** same bits with `Z_en` toggling 1,0,1,0… → identical `Word_out` = 8'hB2; `Fill_cnt` holds during gaps.
- **Backpressure drop:** `Word_ready` = 0, feed 16 bits (0xFF, then 0x0F) → `Word_out` stays 8'hFF with `Ones_out` = 8, and `Drop` = 1 after the 16th bit. Then raise `Word_ready` → `Word_valid` falls next cycle; `Drop` stays 1.
- **Simultaneous accept/load:** hold word 8'hA5 and raise `Word_ready` on the edge where 8'h3C completes → `Word_out` = 8'h3C, `Ones_out` = 4, `Word_valid` stays 1, `Drop` = 0.
- **Reset mid-word:** feed 5 bits, assert `Reset` 1 cycle, then feed 8'h81 → `Word_out` = 8'h81, `Ones_out` = 2; the partial bits never appear.

Source files
------------

// File: rtl/z_pack_pkg.sv
// ----------------------------------------------------------------------------
// z_pack_pkg
//   Items shared by the Z word packer and its popcount helper.
//   - WIDTH_DEFAULT : default number of bits in one packed word
//   - out_state_t   : state of the output register (EMPTY / FULL)
// ----------------------------------------------------------------------------
package z_pack_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage : z_pack_pkg

// File: rtl/z_word_packer_popcount.sv
// ----------------------------------------------------------------------------
// popcount
//   Purely combinational count of the 1 bits in a WIDTH-bit vector.
//   Ports:
//     bits_i  [WIDTH-1:0] : vector to be counted
//     count_o [CW-1:0]    : number of bits of bits_i that are 1
// ----------------------------------------------------------------------------
module popcount
    import z_pack_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CW-1:0]    count_o
);

    // Straight adder chain over every bit; synthesis turns it into a tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule : popcount

// File: rtl/z_word_packer.sv
// ----------------------------------------------------------------------------
// z_word_packer
//   Samples the serial FSM output Z on edges qualified by Z_en and packs the
//   bits MSB-first into WIDTH-bit words. Each completed word is offered with
//   its ones count on a valid/ready port. A word that completes while the
//   output register is still holding an unaccepted word is discarded and the
//   sticky Drop flag is raised.
//   Ports:
//     CLK        : clock, all logic on posedge
//     Reset      : synchronous active-high reset
//     Z          : serial input bit
//     Z_en       : sample qualifier for Z
//     Word_out   : packed word, first-sampled bit in [WIDTH-1]
//     Ones_out   : number of 1s in Word_out
//     Word_valid : Word_out/Ones_out hold an unconsumed word
//     Word_ready : consumer accepts the word when Word_valid is also high
//     Drop       : sticky flag, a completed word was lost
//     Fill_cnt   : number of bits in the partial word
// ----------------------------------------------------------------------------
module z_word_packer
    import z_pack_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Z,
    input  logic             Z_en,
    output logic [WIDTH-1:0] Word_out,
    output logic [CW-1:0]    Ones_out,
    output logic             Word_valid,
    input  logic             Word_ready,
    output logic             Drop,
    output logic [CW-1:0]    Fill_cnt
);

    // Only WIDTH-1 bits of history are kept: the last bit of a word comes
    // straight from Z on the completing edge.
    logic [WIDTH-2:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    fillCnt_q, fillCnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic             drop_q, drop_d;
    out_state_t       state_q, state_d;

    logic [WIDTH-1:0] nextShift;
    logic [CW-1:0]    nextOnes;
    logic             wordDone;

    assign nextShift = {shiftReg_q, Z};

    popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .bits_i  (nextShift),
        .count_o (nextOnes)
    );

    // Fill path: shift in Z on qualified edges; on the last bit of a word
    // flag completion and restart the partial word from empty.
    always_comb begin
        shiftReg_d = shiftReg_q;
        fillCnt_d  = fillCnt_q;
        wordDone   = 1'b0;
        if (Z_en) begin
            if (fillCnt_q == CW'(WIDTH - 1)) begin
                wordDone   = 1'b1;
                shiftReg_d = '0;
                fillCnt_d  = '0;
            end else begin
                shiftReg_d = nextShift[WIDTH-2:0];
                fillCnt_d  = fillCnt_q + 1'b1;
            end
        end
    end

    // Output FSM: a completed word loads when the register is empty or is
    // being emptied on this same edge; otherwise it is dropped and the held
    // word is left untouched.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ones_d  = ones_q;
        drop_d  = drop_q;
        case (state_q)
            EMPTY: begin
                if (wordDone) begin
                    word_d  = nextShift;
                    ones_d  = nextOnes;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (wordDone) begin
                    if (Word_ready) begin
                        word_d = nextShift;
                        ones_d = nextOnes;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (Word_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // All state registers; reset wins over every other input on its edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            shiftReg_q <= '0;
            fillCnt_q  <= '0;
            word_q     <= '0;
            ones_q     <= '0;
            drop_q     <= 1'b0;
            state_q    <= EMPTY;
        end else begin
            shiftReg_q <= shiftReg_d;
            fillCnt_q  <= fillCnt_d;
            word_q     <= word_d;
            ones_q     <= ones_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
        end
    end

    assign Word_out   = word_q;
    assign Ones_out   = ones_q;
    assign Word_valid = (state_q == FULL);
    assign Drop       = drop_q;
    assign Fill_cnt   = fillCnt_q;

endmodule : z_word_packer

// File: tb/tb_z_word_packer.sv
// ----------------------------------------------------------------------------
// tb_z_word_packer
//   Self-checking bench for z_word_packer (WIDTH = 8). Stimulus drives one
//   clock edge at a time and updates a bit-queue reference model; words the
//   model expects to be loaded are queued and compared by a monitor that
//   watches the output port at the falling edge.
// ----------------------------------------------------------------------------
module tb_z_word_packer;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]  word;
        logic [CW-1:0] ones;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          z;
    logic          zEn;
    logic          ready;
    logic [W-1:0]  wordOut;
    logic [CW-1:0] onesOut;
    logic          wordValid;
    logic          drop;
    logic [CW-1:0] fillCnt;

    int   checks;
    int   errors;
    bit   monitorOn;

    // Reference model: pending bits of the partial word, whether a word is
    // held at the output, and the sticky drop flag.
    bit   bitsQ[$];
    exp_t sb[$];
    bit   mValid;
    bit   mDrop;

    z_word_packer #(
        .WIDTH (W)
    ) dut (
        .CLK        (clk),
        .Reset      (rst),
        .Z          (z),
        .Z_en       (zEn),
        .Word_out   (wordOut),
        .Ones_out   (onesOut),
        .Word_valid (wordValid),
        .Word_ready (ready),
        .Drop       (drop),
        .Fill_cnt   (fillCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge with the inputs the DUT sees on it.
    task automatic modelEdge(input logic r, input logic en, input logic zb, input logic rdy);
        bit   handshake;
        bit   completed;
        exp_t e;
        if (r) begin
            bitsQ.delete();
            sb.delete();
            mValid = 0;
            mDrop  = 0;
        end else begin
            handshake = mValid && rdy;
            completed = 0;
            if (en) begin
                bitsQ.push_back(zb);
                if (bitsQ.size() == W) begin
                    int w = 0;
                    int n = 0;
                    foreach (bitsQ[i]) begin
                        w = w * 2 + int'(bitsQ[i]);
                        n = n + int'(bitsQ[i]);
                    end
                    e.word = W'(w);
                    e.ones = CW'(n);
                    completed = 1;
                    bitsQ.delete();
                end
            end
            if (completed) begin
                if (!mValid || handshake) begin
                    mValid = 1;
                    sb.push_back(e);
                end else begin
                    mDrop = 1;
                end
            end else if (handshake) begin
                mValid = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic zb, input logic rdy);
        rst   = r;
        zEn   = en;
        z     = zb;
        ready = rdy;
        @(posedge clk);
        modelEdge(r, en, zb, rdy);
        #1;
    endtask

    // Feed one byte MSB-first; the final bit may use a different ready.
    task automatic sendByte(input logic [W-1:0] val, input logic rdy, input logic lastRdy, input bit gapped);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, val[i], (i == 0) ? lastRdy : rdy);
            if (gapped && i > 0) applyStimulus(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    // Monitor: state outputs against the model every cycle, the held word
    // against the scoreboard head, and pop the head when it is accepted.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("valid", 32'(wordValid), 32'(mValid));
            checkOutput("drop", 32'(drop), 32'(mDrop));
            checkOutput("fill_cnt", 32'(fillCnt), 32'(bitsQ.size()));
            if (mValid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    checkOutput("word", 32'(wordOut), 32'(sb[0].word));
                    checkOutput("ones", 32'(onesOut), 32'(sb[0].ones));
                    if (ready && !rst) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        monitorOn = 0;
        mValid    = 0;
        mDrop     = 0;
        rst = 1'b1; z = 1'b0; zEn = 1'b0; ready = 1'b0;

        // Reset and idle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        monitorOn = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_word", 32'(wordOut), 32'h0);
        checkOutput("idle_ones", 32'(onesOut), 32'h0);
        checkOutput("idle_valid", 32'(wordValid), 32'h0);
        checkOutput("idle_drop", 32'(drop), 32'h0);
        checkOutput("idle_fill", 32'(fillCnt), 32'h0);

        // Basic pack
        sendByte(8'hB2, 1'b1, 1'b1, 0);
        checkOutput("basic_word", 32'(wordOut), 32'hB2);
        checkOutput("basic_ones", 32'(onesOut), 32'd4);
        checkOutput("basic_valid", 32'(wordValid), 32'd1);
        checkOutput("basic_drop", 32'(drop), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("basic_valid_fall", 32'(wordValid), 32'd0);

        // Gapped enable
        sendByte(8'hB2, 1'b1, 1'b1, 1);
        checkOutput("gap_word", 32'(wordOut), 32'hB2);
        checkOutput("gap_ones", 32'(onesOut), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure drop
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendByte(8'hFF, 1'b0, 1'b0, 0);
        sendByte(8'h0F, 1'b0, 1'b0, 0);
        checkOutput("bp_word", 32'(wordOut), 32'hFF);
        checkOutput("bp_ones", 32'(onesOut), 32'd8);
        checkOutput("bp_drop", 32'(drop), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_valid_fall", 32'(wordValid), 32'd0);
        checkOutput("bp_drop_sticky", 32'(drop), 32'd1);

        // Simultaneous accept and load
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendByte(8'hA5, 1'b0, 1'b0, 0);
        sendByte(8'h3C, 1'b0, 1'b1, 0);
        checkOutput("sim_word", 32'(wordOut), 32'h3C);
        checkOutput("sim_ones", 32'(onesOut), 32'd4);
        checkOutput("sim_valid", 32'(wordValid), 32'd1);
        checkOutput("sim_drop", 32'(drop), 32'd0);

        // Reset mid-word
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_fill", 32'(fillCnt), 32'd0);
        sendByte(8'h81, 1'b1, 1'b1, 0);
        checkOutput("mid_word", 32'(wordOut), 32'h81);
        checkOutput("mid_ones", 32'(onesOut), 32'd2);

        // Randomized traffic with changing backpressure levels
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, en, zb, rdy;
            int   phase;
            phase = (cyc / 500) % 3;
            r     = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 3) != 0);
            zb    = 1'($urandom);
            case (phase)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = ($urandom_range(0, 9) == 0);
            endcase
            applyStimulus(r, en, zb, rdy);
        end

        // Drain whatever word is still held
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);

        monitorOn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_z_word_packer
